// File: rtl/spi_target_pkg.sv
// -----------------------------------------------------------------------------
// spi_target_pkg
// Shared types and default constants for the SPI target responder slice.
//   state_t          : frame state of the responder (IDLE / ACTIVE)
//   DEF_WIDTH        : default frame length in bits
//   DEF_SYNC_STAGES  : default synchronizer depth for the SPI pins
// -----------------------------------------------------------------------------
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// N-stage synchronizer for one asynchronous pin, followed by rise/fall
// detection against a one-cycle-delayed copy of the synchronized level.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   async_i  in  : asynchronous pin
//   sync_o   out : synchronized level
//   rise_o   out : one-cycle strobe, synchronized level went 0 -> 1
//   fall_o   out : one-cycle strobe, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge
    import spi_target_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   dly_q;

    // The delayed copy resets to the same value as the chain so that leaving
    // reset never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_p[SYNC_STAGES-1];
    assign rise_o = sync_o & ~dly_q;
    assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/spi_target_responder.sv
// -----------------------------------------------------------------------------
// spi_target_responder
// Mode-0, MSB-first SPI target, oversampled in the system clock domain.
// Received bytes are presented with a one-cycle strobe; the byte to return
// on MISO is supplied through a single-entry valid/ready buffer.
//   clk       in  : system clock (only clock)
//   rst_n     in  : asynchronous active-low reset
//   sck_i     in  : SPI clock from master (asynchronous)
//   cs_n_i    in  : chip select, active low (asynchronous)
//   mosi_i    in  : master-out data (asynchronous)
//   miso_o    out : target-out data, 0 when not driven
//   miso_oe   out : MISO drive enable, high while selected
//   rx_data   out : last complete received byte
//   rx_valid  out : one-cycle strobe, rx_data is new
//   tx_data   in  : next byte to send
//   tx_valid  in  : tx_data offered
//   tx_ready  out : TX buffer empty, offer will be taken
//   busy      out : frame in progress (synchronized CS_N low)
//   underrun  out : one-cycle strobe, DEFAULT_TX loaded for lack of data
//   abort     out : one-cycle strobe, CS_N rose mid-byte
// -----------------------------------------------------------------------------
module spi_target_responder
    import spi_target_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [WIDTH-1:0] DEFAULT_TX  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             underrun,
    output logic             abort
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Synchronized pin views
    logic sck_lvl_unused;   // only SCK edges matter, not its level
    logic sck_rise;
    logic sck_fall;
    logic cs_n_s;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_p;

    // Frame state and datapath
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full;
    logic             reload_pend;

    logic             wr_en;
    logic             load_en;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sck_i),
        .sync_o  (sck_lvl_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (cs_n_i),
        .sync_o  (cs_n_s),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // MOSI only needs its level; it is sampled on synchronized SCK rise,
    // which shares the same latency as this chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_p <= '0;
        end else begin
            mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosi_s = mosi_p[SYNC_STAGES-1];

    // A load moves the buffered byte (or DEFAULT_TX) into the TX shifter:
    // once at frame entry and once after each completed byte, on the SCK
    // falling edge where the next byte's MSB must appear.
    assign wr_en   = tx_valid & ~buf_full;
    assign load_en = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && sck_fall && reload_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            reload_pend <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
            abort       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;

            // A load with a full buffer drains it (no write can coincide,
            // tx_ready is low). A load with an empty buffer takes DEFAULT_TX
            // and any write in the same cycle still lands in the buffer.
            if (load_en && buf_full) begin
                buf_full <= 1'b0;
            end else if (wr_en) begin
                buf_q    <= tx_data;
                buf_full <= 1'b1;
            end

            if (load_en) begin
                tx_shift <= buf_full ? buf_q : DEFAULT_TX;
                underrun <= ~buf_full;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        // Partial byte is dropped; whatever sat in tx_shift
                        // is lost, the buffer is left alone.
                        state       <= IDLE;
                        abort       <= (bit_cnt != '0);
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt     <= '0;
                            rx_data     <= {rx_shift[WIDTH-2:0], mosi_s};
                            rx_valid    <= 1'b1;
                            reload_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (reload_pend) begin
                            reload_pend <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = ~cs_n_s;
    assign miso_oe  = ~cs_n_s;
    assign miso_o   = miso_oe & tx_shift[WIDTH-1];
    assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_target_responder.sv
module tb_spi_target_responder;

    localparam int HALF = 8;    // SCK = clk/16

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sck_i    = 1'b0;
    logic       cs_n_i   = 1'b1;
    logic       mosi_i   = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso_o;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic       busy;
    logic       underrun;
    logic       abort;

    int n_chk   = 0;
    int n_fail  = 0;
    int und_cnt = 0;
    int abt_cnt = 0;
    int rxv_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    spi_target_responder #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DEFAULT_TX  (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck_i    (sck_i),
        .cs_n_i   (cs_n_i),
        .mosi_i   (mosi_i),
        .miso_o   (miso_o),
        .miso_oe  (miso_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .underrun (underrun),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops expected RX bytes, counts strobes
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rxv_cnt++;
                if (rx_q.size() == 0) check_eq("rx_unexpected", 32'(rx_q.size()), 32'd1);
                else                  check_eq("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
            if (underrun) und_cnt++;
            if (abort)    abt_cnt++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rx_data"},  32'(rx_data),  32'd0);
        check_eq({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check_eq({pfx, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check_eq({pfx, "_miso_o"},   32'(miso_o),   32'd0);
        check_eq({pfx, "_miso_oe"},  32'(miso_oe),  32'd0);
        check_eq({pfx, "_busy"},     32'(busy),     32'd0);
        check_eq({pfx, "_underrun"}, 32'(underrun), 32'd0);
        check_eq({pfx, "_abort"},    32'(abort),    32'd0);
    endtask

    // Master side: set MOSI while SCK low, sample MISO just before SCK rises
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi_i = b[7-i];
            wait_clk(HALF);
            got[7-i] = miso_o;
            sck_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] mosi_b, input logic [7:0] exp_miso);
        logic [7:0] got;
        rx_q.push_back(mosi_b);
        miso_q.push_back(exp_miso);
        send_bits(mosi_b, 8, got);
        check_eq("miso_byte", 32'(got), 32'(miso_q.pop_front()));
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n_i = 1'b0;
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        cs_n_i = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic write_tx(input logic [7:0] b);
        int cyc = 0;
        @(negedge clk);
        while (!tx_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!tx_ready) begin
            check_eq("tx_ready_timeout", 32'(tx_ready), 32'd1);
        end else begin
            tx_data  = b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] got;
        int u0, a0, r0, cyc;

        // Reset state
        wait_clk(3);
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(3);

        // T1: A5 in, preloaded 3C out, buffer refilled so no underrun
        write_tx(8'h3C);
        u0 = und_cnt; a0 = abt_cnt;
        cs_low();
        fork
            send_byte(8'hA5, 8'h3C);
            write_tx(8'h96);
        join
        cs_high();
        check_eq("t1_rx_drain",  32'(rx_q.size()),    32'd0);
        check_eq("t1_underrun",  32'(und_cnt - u0),   32'd0);
        check_eq("t1_abort",     32'(abt_cnt - a0),   32'd0);

        // T2: three bytes back-to-back, TX refilled whenever ready
        write_tx(8'hA1);
        u0 = und_cnt;
        cs_low();
        fork
            begin
                send_byte(8'h01, 8'hA1);
                send_byte(8'h02, 8'hB2);
                send_byte(8'h03, 8'hB3);
            end
            begin
                write_tx(8'hB2);
                write_tx(8'hB3);
                write_tx(8'hC4);
            end
        join
        cs_high();
        check_eq("t2_rx_drain",  32'(rx_q.size()),  32'd0);
        check_eq("t2_underrun",  32'(und_cnt - u0), 32'd0);

        // T3: empty buffer -> underrun at CS fall, MISO shifts DEFAULT_TX
        u0 = und_cnt;
        cs_low();
        wait_clk(5);
        check_eq("t3_underrun_cs", 32'(und_cnt - u0), 32'd1);
        check_eq("t3_busy",        32'(busy),         32'd1);
        check_eq("t3_miso_oe",     32'(miso_oe),      32'd1);
        send_byte(8'h5C, 8'h00);
        cs_high();
        check_eq("t3_rx_drain",    32'(rx_q.size()),  32'd0);
        check_eq("t3_underrun",    32'(und_cnt - u0), 32'd2);

        // T4: abort after 5 bits, then full FF frame
        u0 = und_cnt; a0 = abt_cnt; r0 = rxv_cnt;
        cs_low();
        send_bits(8'hC3, 5, got);
        cs_high();
        check_eq("t4_abort",      32'(abt_cnt - a0), 32'd1);
        check_eq("t4_no_rxvalid", 32'(rxv_cnt - r0), 32'd0);
        cs_low();
        send_byte(8'hFF, 8'h00);
        cs_high();
        check_eq("t4_rx_drain",   32'(rx_q.size()),  32'd0);
        check_eq("t4_abort_once", 32'(abt_cnt - a0), 32'd1);
        check_eq("t4_underrun",   32'(und_cnt - u0), 32'd3);

        // T5: write lands on the exact load cycle with empty buffer
        u0 = und_cnt;
        @(negedge clk);
        cs_n_i = 1'b0;
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!busy) begin
            check_eq("t5_busy_timeout", 32'(busy), 32'd1);
        end else begin
            tx_data  = 8'hE7;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        wait_clk(2);
        check_eq("t5_underrun_cs", 32'(und_cnt - u0), 32'd1);
        check_eq("t5_buf_full",    32'(tx_ready),     32'd0);
        send_byte(8'h11, 8'h00);
        send_byte(8'h22, 8'hE7);
        cs_high();
        check_eq("t5_rx_drain",    32'(rx_q.size()),  32'd0);
        check_eq("t5_underrun",    32'(und_cnt - u0), 32'd2);

        // T6: reset mid-byte, then fresh 5A frame
        cs_low();
        wait_clk(5);
        write_tx(8'h99);
        send_bits(8'hF0, 3, got);
        check_eq("t6_pre_ready", 32'(tx_ready), 32'd0);
        check_eq("t6_pre_oe",    32'(miso_oe),  32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        cs_n_i = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        check_eq("t6_idle_busy", 32'(busy), 32'd0);
        u0 = und_cnt; a0 = abt_cnt;
        cs_low();
        send_byte(8'h5A, 8'h00);
        cs_high();
        check_eq("t6_rx_drain",  32'(rx_q.size()),  32'd0);
        check_eq("t6_underrun",  32'(und_cnt - u0), 32'd2);
        check_eq("t6_abort",     32'(abt_cnt - a0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
